tron_game_ctrl: RTL and testbench
=================================

Name: tron_game_ctrl

Overview:
Round/match sequencer for the two-player Tron game. Gates the snake-advance tick and issues trail clear/initialisation. Latches per-frame crash indications from the pixel-scan collision logic and decides round winners. Keeps scores and ends the match at WIN_SCORE. Sits between the update-tick generator, keyboard decoder and pixel pipeline, and the snake datapath/renderer.

Parameters:
WIN_SCORE, 5, rounds needed to win the match (1..2^SCORE_W-1)
SCORE_W, 3, score counter width
COUNT_TICKS, 3, countdown length in ticks before play
END_TICKS, 4, pause length in ticks after a round ends

Ports:
clk  in  1  system clock (all logic on posedge)
reset  in  1  synchronous, active-low reset (0 = reset)
start_key  in  1  one-cycle pulse, start/restart key decoded from keyboard
tick  in  1  one-cycle game-tick enable (update rate)
frame_end  in  1  one-cycle pulse at the last visible pixel of each frame
crash1_pix  in  1  per-pixel: head1 overlaps border or any trail
crash2_pix  in  1  per-pixel: head2 overlaps border or any trail
move_en  out  1  one-cycle pulse, snakes advance one cell (tick qualified by PLAY)
clear_trails  out  1  one-cycle pulse, datapath reloads start positions/clears trails
countdown  out  2  remaining countdown ticks for display (0 outside COUNTDOWN)
score1  out  SCORE_W  player 1 rounds won
score2  out  SCORE_W  player 2 rounds won
round_winner  out  2  01 = P1, 10 = P2, 11 = draw, 00 = none
match_over  out  1  high in MATCH_OVER
state_o  out  3  current state encoding

Behaviour:
- Reset (reset==0 at a posedge): state=IDLE, all outputs 0, scores 0, crash latches 0, tick counter 0. Reset wins over every other input in the same cycle, including mid-round.
- All outputs are registered, so each reacts one cycle after its cause.
- IDLE: waits for start_key. Then goes to INIT, and scores clear to 0.
- INIT: lasts exactly 1 cycle. clear_trails=1 in this cycle. Crash latches and round_winner clear. Tick counter loads COUNT_TICKS. Next state COUNTDOWN.
- COUNTDOWN: countdown = tick counter value. Each tick decrements it. A tick that makes it 0 moves to PLAY. move_en stays 0. Crash inputs are ignored.
- PLAY:
  - move_en = tick (registered, one-cycle pulse).
  - crashN_latch sets on any cycle with crashN_pix=1 and holds until evaluation.
  - Evaluation happens on frame_end. It uses latch values including a crash pixel in the frame_end cycle itself.
  - No latch set: stay in PLAY.
  - Only P1 latched: P2 wins the round. round_winner=10, score2+1.
  - Only P2 latched: round_winner=01, score1+1.
  - Both latched: draw. round_winner=11, no score change.
  - Any latch set: latches clear, tick counter loads END_TICKS, go to ROUND_END.
  - A tick and frame_end in the same cycle: move_en still pulses, and the evaluation still applies.
- ROUND_END:
  - move_en=0; round_winner holds.
  - Each tick decrements the counter. On reaching 0:
    - If score1 or score2 == WIN_SCORE, go to MATCH_OVER.
    - Otherwise go to INIT (new round, scores kept).
- MATCH_OVER: match_over=1; scores and round_winner hold. start_key goes to IDLE for 1 cycle, then INIT with scores cleared (same as IDLE+start).
- start_key outside IDLE/MATCH_OVER is ignored. No mid-round restart; reset is the only abort.
- Scores saturate at WIN_SCORE. An increment at WIN_SCORE is suppressed. No wrap-around.
- Unused state encodings return to IDLE on the next cycle with all outputs at reset values.
- The countdown output is always the low 2 bits of the tick counter. COUNT_TICKS ≤ 3 is required.

Decomposition:
- Package tron_pkg:
  - state enum IDLE=0, INIT=1, COUNTDOWN=2, PLAY=3, ROUND_END=4, MATCH_OVER=5.
  - winner constants WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW.
  - default WIN_SCORE/COUNT_TICKS/END_TICKS.
- One natural sub-module: tron_crash_latch. It holds the two sticky flags with set, clear and frame_end evaluate, and outputs the 2-bit verdict. It is instantiated once. The FSM, counters and scores stay in the top.

Test Plan:
- Reset low with start_key=1 -> state IDLE, all outputs 0; release reset, start_key pulse -> clear_trails pulse 1 cycle, then countdown shows 3,2,1 across 3 ticks, then PLAY with move_en pulsing once per tick.
- In PLAY, crash1_pix for one cycle mid-frame, then frame_end -> next cycle round_winner=10, score2=1, state ROUND_END; after 4 ticks, INIT again with clear_trails and score2 still 1.
- crash1_pix and crash2_pix in the same frame (different cycles), plus one crash in the frame_end cycle itself -> round_winner=11, scores unchanged.
- P1 wins 5 rounds (WIN_SCORE=5) -> score1=5, match_over=1 after END_TICKS; further ticks/crashes change nothing; start_key -> scores 0, new INIT.
- Crash inputs during COUNTDOWN and ROUND_END -> ignored, no score change; start_key during PLAY -> ignored.
- Reset asserted in the middle of PLAY with a crash latched -> next cycle IDLE, scores 0, latches 0, no move_en.

Source files
------------

// File: rtl/tron_pkg.sv
// tron_pkg: state encoding, round-winner codes and default parameters for the Tron game controller
package tron_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INIT       = 3'd1,
    COUNTDOWN  = 3'd2,
    PLAY       = 3'd3,
    ROUND_END  = 3'd4,
    MATCH_OVER = 3'd5
  } state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  localparam int DEF_WIN_SCORE   = 5;
  localparam int DEF_SCORE_W     = 3;
  localparam int DEF_COUNT_TICKS = 3;
  localparam int DEF_END_TICKS   = 4;
endpackage

// File: rtl/tron_crash_latch.sv
// tron_crash_latch: sticky per-player crash flags with frame-end verdict
// Ports: clk, reset (sync, active-low); en = round in play; clr = new round;
//        crash1/crash2 = per-pixel head collisions; eval = frame_end;
//        verdict = {p1 crashed, p2 crashed} on an evaluating cycle, else 00
module tron_crash_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic       crash1,
  input  logic       crash2,
  input  logic       eval,
  output logic [1:0] verdict
);
  logic l1, l2, f1, f2;
  // a crash pixel in the evaluating cycle itself still counts
  assign f1 = l1 | crash1;
  assign f2 = l2 | crash2;
  // P1 crashing means P2 wins, so {f1,f2} is already the winner code
  assign verdict = (en && eval) ? {f1, f2} : 2'b00;
  always_ff @(posedge clk)
    if (!reset || clr) {l1, l2} <= 2'b00;
    else if (en) {l1, l2} <= eval ? 2'b00 : {f1, f2};
endmodule

// File: rtl/tron_game_ctrl.sv
// tron_game_ctrl: round/match sequencer for two-player Tron
// Ports: clk, reset (sync, active-low); start_key, tick, frame_end pulses;
//        crash1_pix/crash2_pix per-pixel collisions; registered outputs
//        move_en, clear_trails, countdown, score1, score2, round_winner,
//        match_over, state_o
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int COUNT_TICKS = DEF_COUNT_TICKS,
  parameter int END_TICKS   = DEF_END_TICKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_key,
  input  logic               tick,
  input  logic               frame_end,
  input  logic               crash1_pix,
  input  logic               crash2_pix,
  output logic               move_en,
  output logic               clear_trails,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         round_winner,
  output logic               match_over,
  output logic [2:0]         state_o
);
  localparam logic [SCORE_W-1:0] WS = SCORE_W'(WIN_SCORE);
  state_t state, nstate;
  logic [2:0] cnt, ncnt;
  logic [SCORE_W-1:0] nscore1, nscore2;
  logic [1:0] nwinner, verdict;
  logic restart, nrestart;
  assign state_o = state;
  tron_crash_latch u_latch (
    .clk     (clk),
    .reset   (reset),
    .en      (state == PLAY),
    .clr     (state == INIT),
    .crash1  (crash1_pix),
    .crash2  (crash2_pix),
    .eval    (frame_end),
    .verdict (verdict)
  );
  always_comb begin
    nstate   = state;
    ncnt     = cnt;
    nscore1  = score1;
    nscore2  = score2;
    nwinner  = round_winner;
    nrestart = restart;
    case (state)
      IDLE: if (start_key || restart) begin
        nstate   = INIT;
        nrestart = 1'b0;
        nscore1  = '0;
        nscore2  = '0;
      end
      INIT: begin
        nstate = COUNTDOWN;
        ncnt   = 3'(COUNT_TICKS);
      end
      COUNTDOWN: if (tick) begin
        ncnt   = cnt - 3'd1;
        nstate = cnt == 3'd1 ? PLAY : COUNTDOWN;
      end
      PLAY: if (frame_end && verdict != WIN_NONE) begin
        nstate  = ROUND_END;
        ncnt    = 3'(END_TICKS);
        nwinner = verdict;
        nscore1 = (verdict == WIN_P1 && score1 != WS) ? score1 + 1'b1 : score1;
        nscore2 = (verdict == WIN_P2 && score2 != WS) ? score2 + 1'b1 : score2;
      end
      ROUND_END: if (tick) begin
        ncnt = cnt - 3'd1;
        if (cnt == 3'd1) nstate = (score1 == WS || score2 == WS) ? MATCH_OVER : INIT;
      end
      MATCH_OVER: if (start_key) begin
        // pass through IDLE once, then start automatically with cleared scores
        nstate   = IDLE;
        nrestart = 1'b1;
      end
      default: begin
        nstate   = IDLE;
        ncnt     = '0;
        nscore1  = '0;
        nscore2  = '0;
        nwinner  = WIN_NONE;
        nrestart = 1'b0;
      end
    endcase
    if (nstate == INIT) nwinner = WIN_NONE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      restart      <= 1'b0;
      score1       <= '0;
      score2       <= '0;
      round_winner <= WIN_NONE;
      move_en      <= 1'b0;
      clear_trails <= 1'b0;
      countdown    <= 2'd0;
      match_over   <= 1'b0;
    end else begin
      state        <= nstate;
      cnt          <= ncnt;
      restart      <= nrestart;
      score1       <= nscore1;
      score2       <= nscore2;
      round_winner <= nwinner;
      move_en      <= state == PLAY && tick;
      clear_trails <= nstate == INIT;
      countdown    <= nstate == COUNTDOWN ? ncnt[1:0] : 2'd0;
      match_over   <= nstate == MATCH_OVER;
    end
endmodule

// File: tb/tb_tron_game_ctrl.sv
// tb_tron_game_ctrl: directed scoreboard bench for tron_game_ctrl
module tb_tron_game_ctrl;
  localparam int SK = 1, TK = 2, FE = 4, C1 = 8, C2 = 16, RST = 32;
  logic clk = 1'b0, reset = 1'b0, start_key = 1'b0, tick = 1'b0, frame_end = 1'b0;
  logic crash1_pix = 1'b0, crash2_pix = 1'b0;
  logic move_en, clear_trails, match_over;
  logic [1:0] countdown, round_winner;
  logic [2:0] score1, score2, state_o;
  logic [15:0] act;
  typedef struct {
    string n;
    int c;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, compared = 0, mismatched = 0;
  tron_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start_key    (start_key),
    .tick         (tick),
    .frame_end    (frame_end),
    .crash1_pix   (crash1_pix),
    .crash2_pix   (crash2_pix),
    .move_en      (move_en),
    .clear_trails (clear_trails),
    .countdown    (countdown),
    .score1       (score1),
    .score2       (score2),
    .round_winner (round_winner),
    .match_over   (match_over),
    .state_o      (state_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {state_o, move_en, clear_trails, countdown, score1, score2, round_winner, match_over};
  always @(negedge clk)
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      compared++;
      if (e.c != cyc || act != e.v) begin
        mismatched++;
        $display("FAIL %s @cyc %0d: got st/mv/clr/cd/s1/s2/w/mo=%b want %b", e.n, cyc, act, e.v);
      end
    end
  task automatic cyc1(input int m);
    reset      = (m & RST) == 0;
    start_key  = (m & SK) != 0;
    tick       = (m & TK) != 0;
    frame_end  = (m & FE) != 0;
    crash1_pix = (m & C1) != 0;
    crash2_pix = (m & C2) != 0;
    @(posedge clk);
    #1;
    {start_key, tick, frame_end, crash1_pix, crash2_pix} = '0;
    reset = 1'b1;
  endtask
  task automatic exp(input string n, input int st, mv, clr, cd, s1, s2, w, mo);
    exp_t x;
    x.n = n;
    x.c = cyc;
    x.v = {3'(st), 1'(mv), 1'(clr), 2'(cd), 3'(s1), 3'(s2), 2'(w), 1'(mo)};
    q.push_back(x);
  endtask
  task automatic countdown_to_play(input int s1, s2);
    cyc1(0);  exp("cd3", 2, 0, 0, 3, s1, s2, 0, 0);
    cyc1(TK); exp("cd2", 2, 0, 0, 2, s1, s2, 0, 0);
    cyc1(TK | C2); exp("cd1", 2, 0, 0, 1, s1, s2, 0, 0);
    cyc1(TK); exp("play", 3, 0, 0, 0, s1, s2, 0, 0);
  endtask
  task automatic end_round(input int s1, s2, w, last);
    for (int i = 0; i < 3; i++) begin
      cyc1(TK | C1); exp("re_hold", 4, 0, 0, 0, s1, s2, w, 0);
    end
    cyc1(TK);
    if (last != 0) exp("re_to_mo", 5, 0, 0, 0, s1, s2, w, 1);
    else exp("re_to_init", 1, 0, 1, 0, s1, s2, 0, 0);
  endtask
  initial begin
    cyc1(RST | SK); exp("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc1(RST | SK); exp("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc1(SK);       exp("init", 1, 0, 1, 0, 0, 0, 0, 0);
    cyc1(C1);       exp("cd3_crash_ign", 2, 0, 0, 3, 0, 0, 0, 0);
    cyc1(TK);       exp("cd2", 2, 0, 0, 2, 0, 0, 0, 0);
    cyc1(TK | C2);  exp("cd1", 2, 0, 0, 1, 0, 0, 0, 0);
    cyc1(TK);       exp("play", 3, 0, 0, 0, 0, 0, 0, 0);
    cyc1(TK);       exp("move_pulse", 3, 1, 0, 0, 0, 0, 0, 0);
    cyc1(SK);       exp("start_in_play_ign", 3, 0, 0, 0, 0, 0, 0, 0);
    cyc1(FE);       exp("fe_no_crash", 3, 0, 0, 0, 0, 0, 0, 0);
    cyc1(C1);       exp("c1_latched", 3, 0, 0, 0, 0, 0, 0, 0);
    cyc1(FE);       exp("p2_wins", 4, 0, 0, 0, 0, 1, 2, 0);
    cyc1(C2 | FE | SK); exp("re_inputs_ign", 4, 0, 0, 0, 0, 1, 2, 0);
    end_round(0, 1, 2, 0);
    countdown_to_play(0, 1);
    cyc1(C1);       exp("draw_c1", 3, 0, 0, 0, 0, 1, 0, 0);
    cyc1(0);        exp("draw_gap", 3, 0, 0, 0, 0, 1, 0, 0);
    cyc1(FE | C2 | TK); exp("draw", 4, 1, 0, 0, 0, 1, 3, 0);
    end_round(0, 1, 3, 0);
    for (int i = 1; i <= 5; i++) begin
      countdown_to_play(i - 1, 1);
      cyc1(C2 | FE); exp("p1_wins", 4, 0, 0, 0, i, 1, 1, 0);
      end_round(i, 1, 1, i == 5);
    end
    cyc1(TK | C1 | FE); exp("mo_hold", 5, 0, 0, 0, 5, 1, 1, 1);
    cyc1(C2 | TK | FE); exp("mo_hold2", 5, 0, 0, 0, 5, 1, 1, 1);
    cyc1(SK);       exp("mo_to_idle", 0, 0, 0, 0, 5, 1, 1, 0);
    cyc1(0);        exp("restart_init", 1, 0, 1, 0, 0, 0, 0, 0);
    countdown_to_play(0, 0);
    cyc1(C1 | C2);  exp("both_latched", 3, 0, 0, 0, 0, 0, 0, 0);
    cyc1(RST | TK | FE); exp("reset_mid_play", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc1(FE | TK);  exp("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc1(SK);       exp("init_after_reset", 1, 0, 1, 0, 0, 0, 0, 0);
    countdown_to_play(0, 0);
    cyc1(FE | TK);  exp("latches_cleared", 3, 1, 0, 0, 0, 0, 0, 0);
    cyc1(0);
    cyc1(0);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      mismatched += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
